// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among four byte sources.
// Issues a single start pulse per frame and paces grants by a fixed frame interval.
module uart_tx_arbiter #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int FRAME_BITS = 10,
    parameter int GUARD_BITS = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  req,
    input  logic [31:0] req_data,
    output logic [3:0]  grant,
    output logic [1:0]  grant_idx,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic        busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int FRAME_CYCLES = CLKS_PER_BIT * (FRAME_BITS + GUARD_BITS);
    localparam int CNT_W        = $clog2(FRAME_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t           r_state;
    logic [1:0]       r_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_grant;
    logic [1:0]       r_grant_idx;
    logic             r_tx_start;
    logic [7:0]       r_tx_data;
    logic             r_busy;

    state_t           w_state_nxt;
    logic [1:0]       w_ptr_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [3:0]       w_grant_nxt;
    logic [1:0]       w_grant_idx_nxt;
    logic             w_tx_start_nxt;
    logic [7:0]       w_tx_data_nxt;
    logic             w_busy_nxt;
    logic [1:0]       w_win;
    logic             w_found;

    // Round-robin search starting at the pointer: first requester in order p..p+3 wins.
    always_comb begin
        logic [1:0] v_cand;
        logic       v_hit;
        w_win   = r_ptr;
        w_found = 1'b0;
        v_cand  = 2'b00;
        v_hit   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            v_cand  = r_ptr + 2'(k);
            v_hit   = !w_found && req[v_cand];
            w_win   = v_hit ? v_cand : w_win;
            w_found = w_found | v_hit;
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_cnt_nxt       = r_cnt;
        w_grant_nxt     = 4'b0000;
        w_grant_idx_nxt = r_grant_idx;
        w_tx_start_nxt  = 1'b0;
        w_tx_data_nxt   = r_tx_data;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt     = ST_SEND;
                    w_grant_nxt     = 4'b0001 << w_win;
                    w_grant_idx_nxt = w_win;
                    w_tx_start_nxt  = 1'b1;
                    w_tx_data_nxt   = req_data[{w_win, 3'b000} +: 8];
                    w_cnt_nxt       = CNT_LOAD;
                    w_ptr_nxt       = w_win + 2'd1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SEND: begin
                // The SEND cycle already counts as the first cycle of the frame.
                if (r_cnt == CNT_ZERO) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = r_cnt - CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (r_cnt == CNT_ZERO) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = CNT_ZERO;
            end
        endcase
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    // State and output registers; reset abandons any in-flight frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= 2'd0;
            r_cnt       <= CNT_ZERO;
            r_grant     <= 4'b0000;
            r_grant_idx <= 2'd0;
            r_tx_start  <= 1'b0;
            r_tx_data   <= 8'h00;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_cnt       <= w_cnt_nxt;
            r_grant     <= w_grant_nxt;
            r_grant_idx <= w_grant_idx_nxt;
            r_tx_start  <= w_tx_start_nxt;
            r_tx_data   <= w_tx_data_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign grant     = r_grant;
    assign grant_idx = r_grant_idx;
    assign tx_start  = r_tx_start;
    assign tx_data   = r_tx_data;
    assign busy      = r_busy;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmitter among four byte requesters with round-robin fairness. The transmitter has no busy/done output, so this block owns frame pacing: it issues one start pulse with stable data, then holds off the next grant for a fixed frame interval derived from the baud rate. It sits between the switch/button front end (and any future byte sources) and the `transmitter` instance, driving its `transmit` and `data` inputs.

## Interface
- CLK_FREQ, 100_000_000, system clock frequency in Hz
- BAUD, 9600, line baud rate
- FRAME_BITS, 10, bits per frame (start + 8 data + stop)
- GUARD_BITS, 1, idle bit-times inserted after each frame
- clk  input  1  system clock, all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- req  input  4  request per source; level, held until granted
- req_data  input  32  byte per source; source i on bits [8i+7:8i], stable while req[i]=1
- grant  output  4  one-hot, one-cycle pulse: byte of source i accepted
- grant_idx  output  2  index of the most recent grant
- tx_start  output  1  one-cycle pulse to transmitter `transmit`
- tx_data  output  8  byte to transmitter `data`, held from grant until next grant
- busy  output  1  frame interval in progress

## Operation
- Derived constants: CLKS_PER_BIT = CLK_FREQ/BAUD (integer divide); FRAME_CYCLES = CLKS_PER_BIT*(FRAME_BITS+GUARD_BITS). Frame counter width = clog2(FRAME_CYCLES+1).
- States: IDLE, SEND, HOLD.
- IDLE: if req != 0, select winner by round-robin and go to SEND; else remain.
- SEND (one cycle): grant[winner]=1, tx_start=1, tx_data loaded with winner's byte, grant_idx=winner, frame counter loaded with FRAME_CYCLES-1, busy=1; go to HOLD.
- HOLD: counter decrements each cycle; busy=1; at counter==0 go to IDLE (busy=0 in IDLE).
- Round robin: pointer p (2 bits) = highest-priority index; search order p, p+1, p+2, p+3 mod 4. After granting i, p = (i+1) mod 4. Pointer unchanged when nothing is granted.
- Winner is sampled from req in IDLE only; requests changing during SEND/HOLD do not affect the current frame.
- A source may drop req before being granted (withdraw); no grant is issued to it.
- A source that keeps req high after its grant is treated as a new request for the next byte.
- tx_data is registered; it never changes outside SEND.
- Reset (any time, including mid-frame): state=IDLE, p=0, counter=0, grant=0, grant_idx=0, tx_start=0, tx_data=0x00, busy=0. The in-flight frame is not retried.

## Timing
- req sampled in IDLE at edge t -> SEND in cycle t+1 (grant, tx_start, tx_data valid together), i.e. 1-cycle latency.
- busy high from SEND cycle for exactly FRAME_CYCLES cycles (SEND + FRAME_CYCLES-1 HOLD cycles).
- Back-to-back: minimum SEND-to-SEND spacing = FRAME_CYCLES + 1 cycles (one IDLE cycle).
- Default params: CLKS_PER_BIT=10416, FRAME_CYCLES=114576 (~1.146 ms), counter 17 bits.
- tx_start is never asserted in two consecutive cycles nor while busy from a prior frame.

## Test plan
Use CLK_FREQ=1000, BAUD=100 (CLKS_PER_BIT=10, FRAME_CYCLES=110).
- Reset then req=0001, req_data[7:0]=0x41 -> next cycle grant=0001, tx_start=1, tx_data=0x41, grant_idx=0; busy high exactly 110 cycles; no further pulse after req dropped on grant.
- req=1111 held with bytes 0x10,0x11,0x12,0x13 -> grants in order 0,1,2,3,0,... with SEND cycles 111 apart; tx_data matches granted source.
- After grant to 2, req=0101 -> next grant is source 0 (search 3,0,1,2); then source 2.
- req[1] pulsed during HOLD and dropped before IDLE -> no grant to 1; busy deasserts on schedule, state stays IDLE.
- reset_n low at HOLD cycle 50 -> all outputs 0 immediately (asynchronous); after release with req=1000, grant to source 3 uses p=0 search order and full 110-cycle frame.
- Simultaneous new req arrival on the cycle the counter reaches 0 -> IDLE cycle occurs, SEND follows one cycle later; spacing exactly 111 cycles.
